// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and two-cycle fetch/execute sequencer with redirect, ecall halt and misalignment trap
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               ecall,
  input  logic               resume,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic               inst_valid,
  output logic               halted,
  output logic               misaligned,
  output logic [31:0]        retired
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT, FAULT} state_t;
  state_t state, state_d;
  logic [31:0] pc_d, inst_q, inst_q_d, retired_d;
  logic resume_q, bad_target;
  assign bad_target = redirect && (redirect_pc[1:0] != 2'b00);
  assign imem_addr  = pc[IMEM_AW+1:2];
  assign inst_valid = state == EXEC;
  assign inst       = inst_valid ? imem_rdata : inst_q;
  assign halted     = state == HALT;
  assign misaligned = state == FAULT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      inst_q   <= NOP_INST;
      retired  <= '0;
      resume_q <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      inst_q   <= inst_q_d;
      retired  <= retired_d;
      resume_q <= resume;
    end
  end
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    inst_q_d  = inst_q;
    retired_d = retired;
    case (state)
      FETCH: state_d = EXEC;
      EXEC: begin
        retired_d = retired + 32'd1;
        if (bad_target) state_d = FAULT;
        else begin
          pc_d     = redirect ? redirect_pc : pc + 32'd4;
          inst_q_d = imem_rdata;
          state_d  = ecall ? HALT : FETCH;
        end
      end
      HALT: state_d = (resume && !resume_q) ? FETCH : HALT;
      default: state_d = FAULT;
    endcase
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and random stimulus checked every cycle against a behavioural fetch model
module tb_inst_fetch;
  localparam int AW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, redirect = 0, ecall = 0, resume = 0;
  logic [31:0] redirect_pc = 0, imem_rdata, inst, pc, retired;
  logic [AW-1:0] imem_addr;
  logic inst_valid, halted, misaligned;
  logic [31:0] rom [256];
  int tests = 0, fails = 0;
  logic [31:0] m_pc = 0, m_last = 0, m_ret = 0;
  int m_ph = 0;
  logic m_rq = 0;
  bit m_known = 0;

  inst_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .ecall(ecall), .resume(resume),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .halted(halted),
    .misaligned(misaligned), .retired(retired)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic ec, input logic rs);
    logic [31:0] idx;
    rst = r; redirect = rd; redirect_pc = rp; ecall = ec; resume = rs;
    #1;
    if (m_known) begin
      idx = (m_pc >> 2) % 256;
      chk("pc", pc, m_pc);
      chk("imem_addr", {24'b0, imem_addr}, idx);
      chk("inst", inst, m_ph == 1 ? rom[idx] : m_last);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_ph == 1});
      chk("halted", {31'b0, halted}, {31'b0, m_ph == 2});
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_ph == 3});
      chk("retired", retired, m_ret);
    end
  endtask

  task automatic adv();
    logic edge_seen;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_last = NOP; m_ret = 0; m_ph = 0; m_rq = 0; m_known = 1;
    end else begin
      edge_seen = resume && !m_rq;
      m_rq = resume;
      case (m_ph)
        0: m_ph = 1;
        1: begin
          m_ret = m_ret + 1;
          if (redirect && redirect_pc % 4 != 0) m_ph = 3;
          else begin
            m_last = rom[(m_pc >> 2) % 256];
            m_pc = redirect ? redirect_pc : m_pc + 4;
            m_ph = ecall ? 2 : 0;
          end
        end
        2: if (edge_seen) m_ph = 0;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rp, input logic ec, input logic rs);
    drive(r, rd, rp, ec, rs);
    adv();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0010_0093; rom[1] = 32'h0020_0113;
    rom[2] = 32'h0030_0193; rom[3] = 32'h0040_0213;
    rom[16] = 32'h0AA0_0513;
    @(negedge clk);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0);
      chk("seq_pc", pc, (c / 2) * 4);
      chk("seq_valid", {31'b0, inst_valid}, c % 2);
      if (c == 0) chk("reset_inst", inst, NOP);
      if (c == 1) chk("first_inst", inst, 32'h0010_0093);
      adv();
    end
    drive(0, 0, 0, 0, 0);
    chk("retired_after_8", retired, 4);
    adv();
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive(0, c == 5, 32'h40, 0, 0);
      if (c == 7) begin
        chk("redir_pc", pc, 32'h40);
        chk("redir_inst", inst, 32'h0AA0_0513);
      end
      adv();
    end
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 17; c++) begin
      drive(c == 15, 0, 0, c == 7 || c == 14, (c >= 7 && c <= 10) || c >= 12);
      if (c == 8) begin
        chk("halt_flag", {31'b0, halted}, 1);
        chk("halt_pc", pc, 32'h10);
      end
      if (c == 11) chk("held_resume", {31'b0, halted}, 1);
      if (c == 14) begin
        chk("resume_pc", pc, 32'h10);
        chk("resume_valid", {31'b0, inst_valid}, 1);
      end
      if (c == 16) begin
        chk("rst_halt_pc", pc, 0);
        chk("rst_halt_flag", {31'b0, halted}, 0);
        chk("rst_halt_ret", retired, 0);
        chk("rst_halt_valid", {31'b0, inst_valid}, 0);
      end
      adv();
    end
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive(c == 7, c == 1, 32'h42, 0, c >= 2 && c % 2 == 0);
      if (c == 2) begin
        chk("fault_flag", {31'b0, misaligned}, 1);
        chk("fault_pc", pc, 0);
      end
      if (c == 6) chk("fault_sticky", {31'b0, misaligned}, 1);
      adv();
    end
    drive(0, 0, 0, 0, 0);
    chk("fault_cleared", {31'b0, misaligned}, 0);
    adv();
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, c == 1, 32'hFFFF_FFFC, 0, 0);
      if (c == 2) begin
        chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_top_addr", {24'b0, imem_addr}, 32'hFF);
      end
      if (c == 4) begin
        chk("wrap_pc", pc, 0);
        chk("wrap_addr", {24'b0, imem_addr}, 0);
      end
      adv();
    end
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rp;
      rp = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 40) == 0) rp = rp | 32'($urandom_range(1, 3));
      step($urandom_range(0, 60) == 0, $urandom_range(0, 4) == 0, rp,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
